instruction_encoder: RTL and testbench
======================================

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 Parameters: none; all widths are fixed by the 32-bit micro-instruction format.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
REQ-006 cmd_op  in  2  00 WRITE, 01 READ, 10 GO, 11 WRITE_BURST.
REQ-007 cmd_addr  in  15  write address / read start address / burst base address.
REQ-008 cmd_arg  in  15  write data / read end address / burst length minus one.
REQ-009 dat_valid  in  1  burst data word offered.
REQ-010 dat_ready  out  1  burst data word accepted when dat_valid&&dat_ready.
REQ-011 dat_data  in  15  burst write data.
REQ-012 instr_valid  out  1  instruction word presented.
REQ-013 instr_ready  in  1  downstream decoder accepts the word.
REQ-014 instr  out  32  encoded micro-instruction.
REQ-015 busy  out  1  high whenever state!=IDLE or instr_valid.
REQ-016 err_range  out  1  one-cycle pulse: READ rejected, start>end.

Function
REQ-017 Encoding: WRITE = {2'b00, addr[14:0], data[14:0]}; READ = {2'b01, start[14:0], end[14:0]}; GO = {2'b10, 30'b0}.
REQ-018 Output register: instr/instr_valid are registered; instr_valid and instr hold stable until instr_ready is sampled high.
REQ-019 Output slot free means !instr_valid || instr_ready (same-cycle drain and reload permitted, giving one word per cycle throughput).
REQ-020 FSM states: IDLE, BURST.
REQ-021 cmd_ready = (state==IDLE) && output slot free; cmd_ready is low in BURST.
REQ-022 Accepted WRITE/READ/GO: the encoded word appears on instr with instr_valid=1 in the next cycle (latency 1); state stays IDLE.
REQ-023 Accepted READ with cmd_addr>cmd_arg (unsigned): no word is emitted, err_range pulses high in the next cycle, and the command is consumed; start==end is legal.
REQ-024 Accepted WRITE_BURST: latch base=cmd_addr and remaining=cmd_arg+1 (range 1..32768, 16-bit counter); go to BURST; no word is emitted for the command itself.
REQ-025 In BURST: dat_ready = output slot free; each data handshake loads a WRITE word {00, addr, dat_data} in the next cycle, then addr increments and remaining decrements.
REQ-026 The burst address wraps modulo 2^15 (7FFF -> 0000) with no error.
REQ-027 The data handshake that consumes the last word (remaining==1) returns the FSM to IDLE; cmd_ready may assert in the following cycle.
REQ-028 In IDLE, dat_ready=0; dat_valid is ignored.
REQ-029 Back-pressure: while instr_valid&&!instr_ready, no command or data is accepted and the output does not change.

Reset
REQ-030 rst forces, at the next edge: state=IDLE, instr_valid=0, instr=32'h0, err_range=0, burst counters cleared; consequently cmd_ready=1 and dat_ready=0 in the following cycle.
REQ-031 A reset during a burst or during a stalled output drops the pending word and the remaining burst with no further output; rst overrides any same-cycle handshake.

Structure
REQ-032 Shared package holds: opcode enum (WRITE, READ, GO, WRITE_BURST), instruction field widths/positions (OP [31:30], A [29:15], B [14:0]), and the FSM state typedef.
REQ-033 Single module; no sub-modules. Encoding is a package function reused by the bench model.

Verification
REQ-034 WRITE addr=0x0012 data=0x7ABC with instr_ready=1 -> next cycle instr=0x00097ABC, instr_valid=1 for one cycle.
REQ-035 READ start=5 end=3 -> no instr_valid, err_range pulse; READ 3..3 -> instr=0x40018003.
REQ-036 GO held with instr_ready=0 for 4 cycles -> instr=0x80000000 stable, cmd_ready=0 throughout; accepted on the 5th cycle.
REQ-037 WRITE_BURST base=0x7FFE arg=2, data 1,2,3 back-to-back -> addresses 7FFE, 7FFF, 0000; three words on consecutive cycles, then IDLE.
REQ-038 rst asserted after 1 of 4 burst words -> instr_valid=0 next cycle, cmd_ready=1, no further words emitted.
REQ-039 Random instr_ready back-pressure over 1000 commands -> output stream matches reference model, no loss or duplication.

Source files
------------

// File: rtl/instruction_encoder_pkg.sv
// rtl/instruction_encoder_pkg.sv - shared opcode, field layout, FSM state and encode helper
package instruction_encoder_pkg;

    localparam int INSTR_W = 32;
    localparam int FIELD_W = 15;
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 30;
    localparam int A_MSB   = 29;
    localparam int A_LSB   = 15;
    localparam int B_MSB   = 14;
    localparam int B_LSB   = 0;

    typedef enum logic [1:0] {
        OP_WRITE       = 2'b00,
        OP_READ        = 2'b01,
        OP_GO          = 2'b10,
        OP_WRITE_BURST = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // GO carries no operands; WRITE_BURST never forms a word of its own.
    function automatic logic [INSTR_W-1:0] encode_instr(
        input op_e                op,
        input logic [FIELD_W-1:0] a,
        input logic [FIELD_W-1:0] b
    );
        logic [INSTR_W-1:0] word;
        word = '0;
        case (op)
            OP_WRITE, OP_READ: begin
                word[OP_MSB:OP_LSB] = op;
                word[A_MSB:A_LSB]   = a;
                word[B_MSB:B_LSB]   = b;
            end
            OP_GO:   word[OP_MSB:OP_LSB] = op;
            default: word = '0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - command/burst-data to 32-bit micro-instruction encoder
module instruction_encoder
    import instruction_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [14:0] cmd_addr,
    input  logic [14:0] cmd_arg,
    input  logic        dat_valid,
    output logic        dat_ready,
    input  logic [14:0] dat_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic        busy,
    output logic        err_range
);

    state_e        state_q, state_d;
    logic [31:0]   instr_q, instr_d;
    logic          instr_valid_q, instr_valid_d;
    logic          err_range_q, err_range_d;
    logic [14:0]   addr_q, addr_d;
    logic [15:0]   remaining_q, remaining_d;

    logic          slot_free;
    logic          cmd_fire;
    logic          dat_fire;
    op_e           op;

    assign op = op_e'(cmd_op);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            err_range_q   <= 1'b0;
            addr_q        <= '0;
            remaining_q   <= '0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            err_range_q   <= err_range_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cmd_fire && op == OP_WRITE_BURST) state_d = ST_BURST;
            ST_BURST: if (dat_fire && remaining_q == 16'd1) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Same-cycle drain and reload keeps one word per cycle flowing.
    always_comb begin
        slot_free = !instr_valid_q || instr_ready;
        cmd_ready = (state_q == ST_IDLE) && slot_free;
        dat_ready = (state_q == ST_BURST) && slot_free;
        cmd_fire  = cmd_valid && cmd_ready;
        dat_fire  = dat_valid && dat_ready;
        busy      = (state_q != ST_IDLE) || instr_valid_q;
    end

    always_comb begin
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q && !instr_ready;
        err_range_d   = 1'b0;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        if (cmd_fire) begin
            case (op)
                OP_READ: begin
                    if (cmd_addr > cmd_arg) begin
                        err_range_d = 1'b1;
                    end else begin
                        instr_d       = encode_instr(op, cmd_addr, cmd_arg);
                        instr_valid_d = 1'b1;
                    end
                end
                OP_WRITE_BURST: begin
                    addr_d      = cmd_addr;
                    remaining_d = {1'b0, cmd_arg} + 16'd1;
                end
                default: begin
                    instr_d       = encode_instr(op, cmd_addr, cmd_arg);
                    instr_valid_d = 1'b1;
                end
            endcase
        end
        if (dat_fire) begin
            instr_d       = encode_instr(OP_WRITE, addr_q, dat_data);
            instr_valid_d = 1'b1;
            addr_d        = addr_q + 15'd1;
            remaining_d   = remaining_q - 16'd1;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign err_range   = err_range_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// tb/tb_instruction_encoder.sv - self-checking bench for instruction_encoder
module tb_instruction_encoder;
    import instruction_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [14:0] cmd_addr = '0;
    logic [14:0] cmd_arg = '0;
    logic        dat_valid = 1'b0;
    logic        dat_ready;
    logic [14:0] dat_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic        busy;
    logic        err_range;

    int checks = 0;
    int failures = 0;

    instruction_encoder dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_arg(cmd_arg),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_data(dat_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .busy(busy), .err_range(err_range)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h expected=%08h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pending output word plus a count of burst words still owed.
    logic        m_valid = 1'b0;
    logic [31:0] m_word = '0;
    logic        m_err = 1'b0;
    int          m_left = 0;
    logic [14:0] m_addr = '0;
    logic        m_cmd_acc = 1'b0;
    int          m_words = 0;
    int          dut_words = 0;
    logic        check_en = 1'b0;

    always @(posedge clk) begin
        logic slot, acc_cmd, acc_dat;
        m_cmd_acc = 1'b0;
        if (rst) begin
            m_valid = 1'b0; m_word = '0; m_err = 1'b0; m_left = 0; m_addr = '0;
        end else begin
            slot    = !m_valid || instr_ready;
            acc_cmd = cmd_valid && (m_left == 0) && slot;
            acc_dat = dat_valid && (m_left != 0) && slot;
            if (m_valid && instr_ready) begin
                m_words++;
                m_valid = 1'b0;
            end
            m_err = 1'b0;
            if (acc_cmd) begin
                m_cmd_acc = 1'b1;
                if (cmd_op == 2'b11) begin
                    m_left = int'(cmd_arg) + 1;
                    m_addr = cmd_addr;
                end else if (cmd_op == 2'b01 && cmd_addr > cmd_arg) begin
                    m_err = 1'b1;
                end else begin
                    m_word  = encode_instr(op_e'(cmd_op), cmd_addr, cmd_arg);
                    m_valid = 1'b1;
                end
            end
            if (acc_dat) begin
                m_word  = encode_instr(OP_WRITE, m_addr, dat_data);
                m_valid = 1'b1;
                m_addr  = m_addr + 15'd1;
                m_left  = m_left - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && instr_valid && instr_ready) dut_words++;
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cyc_instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
            chk("cyc_instr", instr, m_word);
            chk("cyc_err_range", {31'd0, err_range}, {31'd0, m_err});
            chk("cyc_cmd_ready", {31'd0, cmd_ready}, {31'd0, (m_left == 0) && (!m_valid || instr_ready)});
            chk("cyc_dat_ready", {31'd0, dat_ready}, {31'd0, (m_left != 0) && (!m_valid || instr_ready)});
            chk("cyc_busy", {31'd0, busy}, {31'd0, (m_left != 0) || m_valid});
        end
    end

    // Advance one clock; outputs are checked at the negedge and inputs change 1ns later.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] op, input logic [14:0] a, input logic [14:0] b);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_arg = b;
    endtask

    initial begin
        int done_cmds;
        int cycles;
        logic pending;

        // Literal pins of the shared encoder used by the model.
        chk("enc_write", encode_instr(OP_WRITE, 15'h0012, 15'h7ABC), 32'h00097ABC);
        chk("enc_read", encode_instr(OP_READ, 15'd3, 15'd3), 32'h40018003);
        chk("enc_go", encode_instr(OP_GO, 15'h1234, 15'h0567), 32'h80000000);

        step(); step();
        rst = 1'b0;
        check_en = 1'b1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_dat_ready", {31'd0, dat_ready}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        offer(2'b00, 15'h0012, 15'h7ABC);
        step();
        chk("write_instr", instr, 32'h00097ABC);
        chk("write_valid", {31'd0, instr_valid}, 32'd1);
        cmd_valid = 1'b0;
        step();
        chk("write_one_cycle", {31'd0, instr_valid}, 32'd0);

        offer(2'b01, 15'd5, 15'd3);
        step();
        chk("read_bad_err", {31'd0, err_range}, 32'd1);
        chk("read_bad_novalid", {31'd0, instr_valid}, 32'd0);
        offer(2'b01, 15'd3, 15'd3);
        step();
        chk("read_eq_err", {31'd0, err_range}, 32'd0);
        chk("read_eq_instr", instr, 32'h40018003);
        cmd_valid = 1'b0;
        step();

        instr_ready = 1'b0;
        offer(2'b10, 15'd0, 15'd0);
        step();
        offer(2'b00, 15'h0001, 15'h0002);
        for (int i = 0; i < 4; i++) begin
            chk("go_stall_instr", instr, 32'h80000000);
            chk("go_stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("go_stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            if (i < 3) step();
        end
        instr_ready = 1'b1;
        #1;
        chk("go_release_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        step();
        chk("go_next_word", instr, 32'h00008002);
        cmd_valid = 1'b0;
        step();

        offer(2'b11, 15'h7FFE, 15'd2);
        step();
        cmd_valid = 1'b0;
        chk("burst_cmd_noword", {31'd0, instr_valid}, 32'd0);
        dat_valid = 1'b1; dat_data = 15'd1;
        step();
        chk("burst_w0", instr, 32'h3FFF0001);
        dat_data = 15'd2;
        step();
        chk("burst_w1", instr, 32'h3FFF8002);
        dat_data = 15'd3;
        step();
        chk("burst_w2_wrap", instr, 32'h00000003);
        chk("burst_w2_valid", {31'd0, instr_valid}, 32'd1);
        dat_valid = 1'b0;
        step();
        chk("burst_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("burst_idle_busy", {31'd0, busy}, 32'd0);

        offer(2'b11, 15'h0100, 15'd3);
        step();
        cmd_valid = 1'b0;
        dat_valid = 1'b1; dat_data = 15'h0055;
        step();
        chk("rstb_w0", instr, 32'h00800055);
        instr_ready = 1'b0;
        rst = 1'b1;
        step();
        chk("rstb_valid", {31'd0, instr_valid}, 32'd0);
        chk("rstb_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rstb_dat_ready", {31'd0, dat_ready}, 32'd0);
        rst = 1'b0;
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rstb_no_more", {31'd0, instr_valid}, 32'd0);
        end
        dat_valid = 1'b0;

        done_cmds = 0;
        cycles = 0;
        pending = 1'b0;
        while (done_cmds < 1000 && cycles < 30000) begin
            if (pending && m_cmd_acc) begin
                done_cmds++;
                pending = 1'b0;
                cmd_valid = 1'b0;
            end
            if (!pending && $urandom_range(0, 3) != 0) begin
                logic [1:0]  op;
                logic [14:0] a, b;
                op = 2'($urandom_range(0, 3));
                a  = ($urandom_range(0, 3) == 0) ? 15'h7FFD : 15'($urandom);
                b  = (op == 2'b11) ? 15'($urandom_range(0, 4)) : 15'($urandom);
                offer(op, a, b);
                pending = 1'b1;
            end
            instr_ready = ($urandom_range(0, 3) != 0);
            dat_valid   = ($urandom_range(0, 2) != 0);
            dat_data    = 15'($urandom);
            step();
            cycles++;
        end
        chk("rand_cmds_done", done_cmds, 1000);

        cmd_valid = 1'b0;
        dat_valid = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        dat_valid = 1'b0;
        step();
        chk("drain_idle_busy", {31'd0, busy}, 32'd0);
        chk("stream_word_count", dut_words, m_words);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
